// File: rtl/core_pipe_pkg.sv
// Shared pipeline types for the core: EX/MEM payload layout and counter defaults.
package core_pipe_pkg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data_2;
    logic [4:0]  rd_num;
    logic [4:0]  addr_reg_2;
    logic        mem_write_en;
    logic        mem_to_reg;
    logic        reg_write;
    logic        reg_write_coprocessor;
    logic        is_mem_inst;
    logic        is_word;
    logic        halted;
  } ex_mem_payload_t;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// Generic valid/ready channel carrying one W-bit payload per transfer.
interface ex_mem_skid_stage_if
  import core_pipe_pkg::*;
#(
  parameter int W = $bits(ex_mem_payload_t)
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; shared by the pipeline performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count <= '0;
    else if (clear)               count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end
endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM stage register with valid/ready handshake, optional 2-entry skid, flush and stall counter.
module ex_mem_skid_stage
  import core_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = $bits(ex_mem_payload_t),
  parameter bit SKID      = 1'b1,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  ex_mem_skid_stage_if.slave  ex_ch,
  ex_mem_skid_stage_if.master mem_ch,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt
);
  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  logic                 skid_valid;
  logic                 in_ready;
  logic                 xfer_in;
  logic                 xfer_out;

  assign xfer_in  = ex_ch.valid && in_ready && !flush;
  assign xfer_out = main_valid && mem_ch.ready;

  assign ex_ch.ready    = in_ready;
  assign mem_ch.valid   = main_valid;
  assign mem_ch.payload = main_payload;
  assign occupancy      = {1'b0, main_valid} + {1'b0, skid_valid};

  if (SKID) begin : g_skid
    logic [PAYLOAD_W-1:0] skid_payload;

    // in_ready comes straight from a flop so the upstream path never sees out_ready
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_valid   <= 1'b0;
        main_payload <= '0;
        skid_valid   <= 1'b0;
        skid_payload <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || xfer_out) begin
        if (skid_valid) begin
          main_valid   <= 1'b1;
          main_payload <= skid_payload;
          skid_valid   <= 1'b0;
        end else begin
          main_valid <= xfer_in;
          if (xfer_in) main_payload <= ex_ch.payload;
        end
      end else if (xfer_in) begin
        skid_valid   <= 1'b1;
        skid_payload <= ex_ch.payload;
      end
    end
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign in_ready   = !main_valid || mem_ch.ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_valid   <= 1'b0;
        main_payload <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (xfer_in) begin
        main_valid   <= 1'b1;
        main_payload <= ex_ch.payload;
      end else if (xfer_out) begin
        main_valid <= 1'b0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (main_valid && !mem_ch.ready),
    .clear (1'b0),
    .count (stall_cnt)
  );
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench: skid stage (default), saturating counter (CNT_W=4) and SKID=0 variants.
module tb_ex_mem_skid_stage;
  import core_pipe_pkg::*;

  localparam int PW = $bits(ex_mem_payload_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   cmp = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  // main DUT: SKID=1, full payload
  ex_mem_skid_stage_if a_ex ();
  ex_mem_skid_stage_if a_mem ();
  logic [1:0]  a_occ;
  logic [15:0] a_stall;
  ex_mem_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_ch(a_ex), .mem_ch(a_mem), .occupancy(a_occ), .stall_cnt(a_stall)
  );

  // saturation DUT: CNT_W=4
  ex_mem_skid_stage_if #(.W(8)) c_ex ();
  ex_mem_skid_stage_if #(.W(8)) c_mem ();
  logic [1:0] c_occ;
  logic [3:0] c_stall;
  ex_mem_skid_stage #(.PAYLOAD_W(8), .SKID(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .ex_ch(c_ex), .mem_ch(c_mem), .occupancy(c_occ), .stall_cnt(c_stall)
  );

  // SKID=0 DUT
  ex_mem_skid_stage_if #(.W(8)) z_ex ();
  ex_mem_skid_stage_if #(.W(8)) z_mem ();
  logic [1:0] z_occ;
  logic [7:0] z_stall;
  ex_mem_skid_stage #(.PAYLOAD_W(8), .SKID(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .ex_ch(z_ex), .mem_ch(z_mem), .occupancy(z_occ), .stall_cnt(z_stall)
  );

  function automatic ex_mem_payload_t mk(input logic [31:0] n);
    ex_mem_payload_t p;
    p             = '0;
    p.alu_result  = n;
    p.read_data_2 = ~n;
    p.rd_num      = n[4:0];
    p.is_mem_inst = n[0];
    p.halted      = ~n[0];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    cmp++; if (a_mem.valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %0b want 0", a_mem.valid); end
    cmp++; if (a_mem.payload !== '0) begin errs++; $display("FAIL rst_payload got %h want 0", a_mem.payload); end
    cmp++; if (a_occ !== 2'd0) begin errs++; $display("FAIL rst_occ got %0d want 0", a_occ); end
    cmp++; if (a_stall !== 16'd0) begin errs++; $display("FAIL rst_stall got %0d want 0", a_stall); end
    @(posedge clk); #1 rst_n = 1'b1;
    cmp++; if (a_ex.ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %0b want 1", a_ex.ready); end
    tick();
    cmp++; if (a_ex.ready !== 1'b1 || a_mem.valid !== 1'b0) begin
      errs++; $display("FAIL rst_idle got in_ready=%0b out_valid=%0b want 1/0", a_ex.ready, a_mem.valid);
    end
  endtask

  task automatic test_pass_through();
    a_mem.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_ex.valid = 1'b1; a_ex.payload = mk(i);
      cmp++; if (a_ex.ready !== 1'b1) begin errs++; $display("FAIL pt_in_ready[%0d] got %0b want 1", i, a_ex.ready); end
      tick();
      cmp++; if (a_mem.valid !== 1'b1 || a_mem.payload !== mk(i)) begin
        errs++; $display("FAIL pt_out[%0d] got v=%0b %h want v=1 %h", i, a_mem.valid, a_mem.payload, mk(i));
      end
    end
    a_ex.valid = 1'b0;
    tick();
    cmp++; if (a_mem.valid !== 1'b0) begin errs++; $display("FAIL pt_drain got %0b want 0", a_mem.valid); end
    cmp++; if (a_stall !== 16'd0) begin errs++; $display("FAIL pt_stall got %0d want 0", a_stall); end
  endtask

  task automatic test_backpressure();
    a_mem.ready = 1'b0;
    a_ex.valid = 1'b1; a_ex.payload = mk(32'hA);
    tick();
    cmp++; if (a_ex.ready !== 1'b1 || a_occ !== 2'd1) begin
      errs++; $display("FAIL bp_one got in_ready=%0b occ=%0d want 1/1", a_ex.ready, a_occ);
    end
    a_ex.payload = mk(32'hB);
    tick();
    a_ex.payload = mk(32'hC);
    cmp++; if (a_occ !== 2'd2) begin errs++; $display("FAIL bp_occ got %0d want 2", a_occ); end
    cmp++; if (a_ex.ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready got %0b want 0", a_ex.ready); end
    cmp++; if (a_mem.payload !== mk(32'hA)) begin errs++; $display("FAIL bp_head got %h want %h", a_mem.payload, mk(32'hA)); end
    cmp++; if (a_stall !== 16'd1) begin errs++; $display("FAIL bp_stall1 got %0d want 1", a_stall); end
    tick();
    cmp++; if (a_stall !== 16'd2 || a_mem.payload !== mk(32'hA)) begin
      errs++; $display("FAIL bp_hold got stall=%0d %h want 2 %h", a_stall, a_mem.payload, mk(32'hA));
    end
    a_mem.ready = 1'b1; a_ex.valid = 1'b0;
    #1;
    cmp++; if (a_ex.ready !== 1'b0) begin errs++; $display("FAIL bp_registered_ready got %0b want 0", a_ex.ready); end
    tick();
    cmp++; if (a_mem.valid !== 1'b1 || a_mem.payload !== mk(32'hB)) begin
      errs++; $display("FAIL bp_second got v=%0b %h want v=1 %h", a_mem.valid, a_mem.payload, mk(32'hB));
    end
    cmp++; if (a_ex.ready !== 1'b1 || a_occ !== 2'd1) begin
      errs++; $display("FAIL bp_release got in_ready=%0b occ=%0d want 1/1", a_ex.ready, a_occ);
    end
    tick();
    cmp++; if (a_mem.valid !== 1'b0 || a_occ !== 2'd0 || a_stall !== 16'd2) begin
      errs++; $display("FAIL bp_empty got v=%0b occ=%0d stall=%0d want 0/0/2", a_mem.valid, a_occ, a_stall);
    end
  endtask

  task automatic test_flush();
    a_mem.ready = 1'b0;
    a_ex.valid = 1'b1; a_ex.payload = mk(32'hD);
    tick();
    a_ex.payload = mk(32'hE);
    tick();
    a_ex.payload = mk(32'hC); flush = 1'b1;
    tick();
    flush = 1'b0; a_ex.valid = 1'b0;
    cmp++; if (a_mem.valid !== 1'b0 || a_occ !== 2'd0) begin
      errs++; $display("FAIL fl_full got v=%0b occ=%0d want 0/0", a_mem.valid, a_occ);
    end
    cmp++; if (a_mem.payload !== mk(32'hD)) begin errs++; $display("FAIL fl_payload_hold got %h want %h", a_mem.payload, mk(32'hD)); end
    cmp++; if (a_stall !== 16'd4) begin errs++; $display("FAIL fl_stall got %0d want 4", a_stall); end
    a_mem.ready = 1'b1;
    tick();
    cmp++; if (a_mem.valid !== 1'b0) begin errs++; $display("FAIL fl_no_c got %0b want 0", a_mem.valid); end
    a_mem.ready = 1'b0;
    a_ex.valid = 1'b1; a_ex.payload = mk(32'hF);
    tick();
    a_ex.payload = mk(32'h10); flush = 1'b1;
    #1;
    cmp++; if (a_ex.ready !== 1'b1) begin errs++; $display("FAIL fl_accepting got %0b want 1", a_ex.ready); end
    tick();
    flush = 1'b0; a_ex.valid = 1'b0;
    tick();
    cmp++; if (a_mem.valid !== 1'b0 || a_occ !== 2'd0 || a_stall !== 16'd5) begin
      errs++; $display("FAIL fl_incoming got v=%0b occ=%0d stall=%0d want 0/0/5", a_mem.valid, a_occ, a_stall);
    end
  endtask

  task automatic test_reset_mid();
    a_mem.ready = 1'b0;
    a_ex.valid = 1'b1; a_ex.payload = mk(32'h21);
    tick();
    a_ex.payload = mk(32'h22);
    tick();
    a_ex.valid = 1'b0;
    cmp++; if (a_occ !== 2'd2) begin errs++; $display("FAIL rm_setup got %0d want 2", a_occ); end
    rst_n = 1'b0;
    #1;
    cmp++; if (a_mem.valid !== 1'b0 || a_mem.payload !== '0) begin
      errs++; $display("FAIL rm_out got v=%0b %h want 0/0", a_mem.valid, a_mem.payload);
    end
    cmp++; if (a_occ !== 2'd0 || a_stall !== 16'd0) begin
      errs++; $display("FAIL rm_state got occ=%0d stall=%0d want 0/0", a_occ, a_stall);
    end
    tick();
    rst_n = 1'b1;
    tick();
    cmp++; if (a_ex.ready !== 1'b1 || a_mem.valid !== 1'b0) begin
      errs++; $display("FAIL rm_release got in_ready=%0b v=%0b want 1/0", a_ex.ready, a_mem.valid);
    end
  endtask

  task automatic test_saturation();
    c_mem.ready = 1'b0;
    c_ex.valid = 1'b1; c_ex.payload = 8'h5A;
    tick();
    c_ex.valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    cmp++; if (c_stall !== 4'd5) begin errs++; $display("FAIL sat_mid got %0d want 5", c_stall); end
    for (int i = 0; i < 15; i++) tick();
    cmp++; if (c_stall !== 4'd15) begin errs++; $display("FAIL sat_top got %0d want 15", c_stall); end
    tick(); tick();
    cmp++; if (c_stall !== 4'd15 || c_mem.payload !== 8'h5A) begin
      errs++; $display("FAIL sat_hold got %0d %h want 15 5a", c_stall, c_mem.payload);
    end
    c_mem.ready = 1'b1;
    tick();
  endtask

  task automatic test_noskid();
    z_mem.ready = 1'b1; z_ex.valid = 1'b1; z_ex.payload = 8'h01;
    #1;
    cmp++; if (z_ex.ready !== 1'b1) begin errs++; $display("FAIL ns_empty_ready got %0b want 1", z_ex.ready); end
    tick();
    z_ex.payload = 8'h02;
    cmp++; if (z_mem.valid !== 1'b1 || z_mem.payload !== 8'h01) begin
      errs++; $display("FAIL ns_first got v=%0b %h want 1 01", z_mem.valid, z_mem.payload);
    end
    tick();
    z_ex.payload = 8'h03; z_mem.ready = 1'b0;
    #1;
    cmp++; if (z_ex.ready !== 1'b0) begin errs++; $display("FAIL ns_ready_low got %0b want 0", z_ex.ready); end
    cmp++; if (z_mem.payload !== 8'h02 || z_occ !== 2'd1) begin
      errs++; $display("FAIL ns_second got %h occ=%0d want 02/1", z_mem.payload, z_occ);
    end
    tick();
    cmp++; if (z_mem.payload !== 8'h02 || z_stall !== 8'd1) begin
      errs++; $display("FAIL ns_stalled got %h stall=%0d want 02/1", z_mem.payload, z_stall);
    end
    z_mem.ready = 1'b1;
    #1;
    cmp++; if (z_ex.ready !== 1'b1) begin errs++; $display("FAIL ns_ready_high got %0b want 1", z_ex.ready); end
    tick();
    z_ex.valid = 1'b0;
    cmp++; if (z_mem.valid !== 1'b1 || z_mem.payload !== 8'h03) begin
      errs++; $display("FAIL ns_third got v=%0b %h want 1 03", z_mem.valid, z_mem.payload);
    end
    tick();
    cmp++; if (z_mem.valid !== 1'b0 || z_stall !== 8'd1) begin
      errs++; $display("FAIL ns_drain got v=%0b stall=%0d want 0/1", z_mem.valid, z_stall);
    end
  endtask

  initial begin
    a_ex.valid = 1'b0; a_ex.payload = '0; a_mem.ready = 1'b0;
    c_ex.valid = 1'b0; c_ex.payload = '0; c_mem.ready = 1'b1;
    z_ex.valid = 1'b0; z_ex.payload = '0; z_mem.ready = 1'b1;
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_saturation();
    test_noskid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised EX→MEM pipeline stage register with valid/ready handshaking, an optional 2-entry skid buffer, flush, and a saturating back-pressure counter. It replaces the plain hold-on-stall EX/MEM latch: the payload (ALU result, store data, destination register, control bits) is generic, and back-pressure from the data cache is expressed as `out_ready` rather than a hold input. It sits between the execute stage and the memory-access stage of the pipelined core.

## Interface
- `PAYLOAD_W`, default `$bits(ex_mem_payload_t)`: width of the carried payload.
- `SKID`, default 1: 1 = 2-entry skid buffer (fully registered `in_ready`); 0 = single register, `in_ready` combinational from `out_ready`.
- `CNT_W`, default 16: width of the stall counter.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of all held and incoming entries.
- `in_valid` input 1: execute stage offers a payload.
- `in_ready` output 1: stage accepts the payload this cycle.
- `in_payload` input PAYLOAD_W: payload from execute.
- `out_valid` output 1: memory stage is offered a payload.
- `out_ready` input 1: memory stage (cache not busy) accepts.
- `out_payload` output PAYLOAD_W: registered payload to memory.
- `occupancy` output 2: number of valid entries held (0..2; max 1 when SKID=0).
- `stall_cnt` output CNT_W: saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Storage: main register (drives `out_*`), plus a skid register when SKID=1. Each register has its own valid bit.
- Transfer in: `in_valid && in_ready && !flush`. Transfer out: `out_valid && out_ready`.
- SKID=1: `in_ready = !skid_valid` (a registered bit, with no combinational path from `out_ready`).
  - Main empty, or main firing: the skid entry (if valid) moves to main; otherwise the incoming entry moves to main.
  - Main valid and not firing, with an incoming entry: the incoming entry goes to skid.
  - Skid valid and main firing: skid moves to main and skid empties. `in_ready` was 0, so there is no incoming entry.
  - Order is strictly FIFO. An entry is never duplicated or dropped except by flush.
- SKID=0: `in_ready = !out_valid || out_ready`. Incoming entries load main directly.
- `flush`: at the next edge all valid bits are 0. A transfer in during the same cycle is discarded. A transfer out during the same cycle still completes, because the consumer has sampled it.
- Payload registers load only on a transfer. They hold their value otherwise, including through flush; only the valid bits clear.
- `stall_cnt`:
  - Increments by 1 each cycle that `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Not cleared by flush; cleared only by reset.
- `occupancy` = main_valid + skid_valid, taken from registered state.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - `out_valid`=0, `out_payload`=0, skid valid=0, skid payload=0.
  - `occupancy`=0, `stall_cnt`=0.
  - `in_ready`=1 in the first cycle after release.
- Reset mid-operation drops all entries immediately. No partial transfer survives.
- Latency: an entry accepted at edge N is presented on `out_*` after edge N (one cycle).
- Throughput: one entry per cycle when `out_ready` is held high, for both SKID values.
- SKID=1: after one stall cycle with `in_valid` held, the skid fills and `in_ready` drops at the following edge. When `out_ready` returns, `in_ready` is 1 again one edge later.
- `out_payload` is stable while `out_valid && !out_ready`.

## Structure
- Shared package `core_pipe_pkg`:
  - `ex_mem_payload_t`, a packed struct with fields alu_result[31:0], read_data_2[31:0], rd_num[4:0], addr_reg_2[4:0], mem_write_en, mem_to_reg, reg_write, reg_write_coprocessor, is_mem_inst, is_word, halted.
  - Default CNT_W constant.
- One sub-module is natural: `sat_counter` (CNT_W, inc, clear → count). It is reused for other stages' performance counters.
- The skid path is generated under `if (SKID)`. No other hierarchy.

## Test plan
- Pass-through: SKID=1, `out_ready`=1, stream payloads 0x1..0x8 back-to-back → the same sequence appears one cycle later, `in_ready` stays 1, `stall_cnt`=0.
- Back-pressure: A then B offered while `out_ready`=0 → main=A, skid=B, `occupancy`=2, `in_ready`=0, `stall_cnt` counting. Release → A, then B, in consecutive cycles.
- Flush with full stage and `in_valid`=1 with C → next cycle `out_valid`=0, `occupancy`=0, and C never appears.
- Saturation: CNT_W=4, `out_ready`=0 for 20 cycles with `out_valid`=1 → `stall_cnt`=15 and holds.
- Reset mid-operation: `rst_n` low while `occupancy`=2 → outputs zero immediately (no clock edge needed). After release `in_ready`=1.
- SKID=0: `out_ready` toggled 1,0,1 with a continuous stream → `in_ready` follows `out_ready` combinationally while full, and there is no loss or duplication.
